// File: rtl/segment_record_fifo.sv
// segment_record_fifo
//   Assembles motion-segment records from fixed-width input beats and stores
//   up to SLOTS complete records, presenting the oldest one whole
//   (first-word-fall-through) to the step engine.
//
//   Optional feature macro: SEGMENT_RECORD_FIFO_ABORT_EN
//     defined   : in_abort discards the partial record being assembled.
//     undefined : in_abort is ignored.
//
// Ports
//   clk, rst      sole clock; synchronous active-high reset
//   in_valid/in_ready/in_data   beat input handshake
//   in_abort      discard partial record (ABORT_EN builds only)
//   flush         discard all stored and partial records
//   out_valid/out_ready/out_record   record output handshake (FWFT)
//   level         number of complete records stored
//   almost_full   level >= ALMOST_FULL
//   overflow      sticky: beat offered while in_ready was low
module segment_record_fifo #(
    parameter int unsigned BEAT_BYTES   = 1,
    parameter int unsigned RECORD_BEATS = 16,
    parameter int unsigned SLOTS        = 32,
    parameter int unsigned ALMOST_FULL  = SLOTS - 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [BEAT_BYTES*8-1:0]                  in_data,
    input  logic                                     in_abort,
    input  logic                                     flush,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [BEAT_BYTES*8*RECORD_BEATS-1:0]     out_record,
    output logic [$clog2(SLOTS+1)-1:0]               level,
    output logic                                     almost_full,
    output logic                                     overflow
);

    localparam int unsigned BEAT_BITS   = BEAT_BYTES * 8;
    localparam int unsigned RECORD_BITS = BEAT_BITS * RECORD_BEATS;
    localparam int unsigned PTR_W       = $clog2(SLOTS);
    localparam int unsigned LVL_W       = $clog2(SLOTS + 1);
    localparam int unsigned CNT_W       = $clog2(RECORD_BEATS);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RECORD_BEATS - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(SLOTS);
    localparam logic [LVL_W-1:0] AF_LVL   = LVL_W'(ALMOST_FULL);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        LAST
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       beat_cnt;
    logic [RECORD_BITS-1:0] staging;
    logic [RECORD_BITS-1:0] commit_word;
    logic [RECORD_BITS-1:0] mem [SLOTS];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LVL_W-1:0]       level_next;
    logic                   abort_act;
    logic                   beat_acc;
    logic                   commit;
    logic                   pop;

`ifdef SEGMENT_RECORD_FIFO_ABORT_EN
    assign abort_act = in_abort;
`else
    logic unused_in_abort;
    assign unused_in_abort = in_abort;
    assign abort_act       = 1'b0;
`endif

    // Only the committing beat can stall; partial beats never wait on space.
    assign in_ready = !((state == LAST) && (level == FULL_LVL));

    assign beat_acc   = in_valid && in_ready && !abort_act;
    assign commit     = beat_acc && (state == LAST);
    assign out_valid  = (level != '0);
    assign pop        = out_valid && out_ready;
    assign out_record = out_valid ? mem[rd_ptr] : '0;

    // Final beat goes straight into the stored word, never through staging.
    always_comb begin
        commit_word = staging;
        commit_word[32'(beat_cnt) * BEAT_BITS +: BEAT_BITS] = in_data;
    end

    always_comb begin
        level_next = level;
        if (commit && !pop)
            level_next = level + 1'b1;
        else if (!commit && pop)
            level_next = level - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && commit)
            mem[wr_ptr] <= commit_word;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            staging     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (abort_act) begin
                state    <= IDLE;
                beat_cnt <= '0;
            end else if (beat_acc) begin
                case (state)
                    IDLE, FILL: begin
                        staging[32'(beat_cnt) * BEAT_BITS +: BEAT_BITS] <= in_data;
                        beat_cnt <= beat_cnt + 1'b1;
                        state    <= (beat_cnt == LAST_CNT - 1'b1) ? LAST : FILL;
                    end
                    default: begin
                        wr_ptr   <= wr_ptr + 1'b1;
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end
                endcase
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            level       <= level_next;
            almost_full <= (level_next >= AF_LVL);
            if (in_valid && !in_ready)
                overflow <= 1'b1;
        end
    end

endmodule
